// File: rtl/digit_frame_renderer_if.sv
// Request/ROM/response bundle between the LCD scan controller, the digit frame
// renderer and the glyph ROM.
interface digit_frame_renderer_if #(
    parameter int N_DIGITS = 4,
    parameter int ROM_AW   = 16
);
    logic                    req_valid;
    logic [7:0]              req_x;
    logic [7:0]              req_y;
    logic [5*N_DIGITS-1:0]   digits;
    logic [4:0]              select;
    logic [ROM_AW-1:0]       rom_addr;
    logic [15:0]             rom_data;
    logic                    rsp_valid;
    logic [15:0]             rsp_data;

    modport slave (
        input  req_valid, req_x, req_y, digits, select, rom_data,
        output rom_addr, rsp_valid, rsp_data
    );

    modport master (
        output req_valid, req_x, req_y, digits, select, rom_data,
        input  rom_addr, rsp_valid, rsp_data
    );
endinterface

// File: rtl/digit_frame_renderer.sv
// Pixel source for the timer digit panel: bordered frame of stacked glyph bands
// plus a separator band, glyphs fetched from an external ROM. Optional blinking
// highlight is enabled by defining DFR_BLINK_EN.
module digit_frame_renderer #(
    parameter int          BORDER       = 12,
    parameter int          GLYPH_W      = 55,
    parameter int          GLYPH_H      = 16,
    parameter int          SCALE        = 2,
    parameter int          N_DIGITS     = 4,
    parameter int          SEP_AFTER    = 2,
    parameter int          SEP_H        = 12,
    parameter int          ROM_LAT      = 1,
    parameter int          ROM_AW       = 16,
    parameter logic [15:0] HL_THRESH    = 16'h0800,
    parameter int          BLINK_CYCLES = 25000000
) (
    input logic                    clk,
    input logic                    rst,
    digit_frame_renderer_if.slave  bus
);

    localparam int BAND_H  = GLYPH_H * SCALE;
    localparam int FRAME_W = 2 * BORDER + GLYPH_W * SCALE;
    localparam int FRAME_H = 2 * BORDER + N_DIGITS * BAND_H + SEP_H;
    localparam int SEP_TOP = BORDER + SEP_AFTER * BAND_H;

    localparam logic [15:0] X_LO  = 16'(BORDER);
    localparam logic [15:0] X_HI  = 16'(FRAME_W - BORDER);
    localparam logic [15:0] Y_LO  = 16'(BORDER);
    localparam logic [15:0] Y_HI  = 16'(FRAME_H - BORDER);
    localparam logic [15:0] SEP_0 = 16'(SEP_TOP);
    localparam logic [15:0] SEP_1 = 16'(SEP_TOP + SEP_H);
    localparam logic [15:0] BH    = 16'(BAND_H);
    localparam logic [15:0] SC    = 16'(SCALE);

    localparam logic [ROM_AW-1:0] ROW_STRIDE   = ROM_AW'(GLYPH_W);
    localparam logic [ROM_AW-1:0] GLYPH_STRIDE = ROM_AW'(GLYPH_W * GLYPH_H);

    if (ROM_LAT < 1 || BLINK_CYCLES < 1) begin : g_bad_param
        $error("digit_frame_renderer: ROM_LAT and BLINK_CYCLES must be >= 1");
    end

    // Border, out-of-range and blank digits all render black, so they share a class.
    typedef enum logic [1:0] {
        CLS_BLANK = 2'd0,
        CLS_DIGIT = 2'd1,
        CLS_SEP   = 2'd2
    } cls_e;

    typedef struct packed {
        logic valid;
        cls_e cls;
        logic hl;
    } tag_t;

    function automatic logic [15:0] band_top(input int k);
        return 16'(BORDER + k * BAND_H + ((k >= SEP_AFTER) ? SEP_H : 0));
    endfunction

    logic              blink_phase;
    tag_t              s0_d, s0_q;
    tag_t              dl_q [ROM_LAT];
    logic [ROM_AW-1:0] rom_addr_d, rom_addr_q;
    logic              rsp_valid_q;
    logic [15:0]       rsp_data_d, rsp_data_q;

    logic [15:0] x16, y16, rel_y, col, row;
    logic [4:0]  digit_v;
    logic        in_frame, addr_upd;
    logic [15:0] pix;

    // Stage 0: classify the pixel and form the glyph address.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        s0_d       = '0;
        addr_upd   = 1'b0;
        digit_v    = '0;
        rel_y      = '0;
        x16        = {8'd0, bus.req_x};
        y16        = {8'd0, bus.req_y};
        in_frame   = (x16 >= X_LO) && (x16 < X_HI) && (y16 >= Y_LO) && (y16 < Y_HI);
        s0_d.valid = bus.req_valid;
        s0_d.cls   = CLS_BLANK;

        if (in_frame) begin
            if (y16 >= SEP_0 && y16 < SEP_1) begin
                s0_d.cls = CLS_SEP;
                s0_d.hl  = (bus.select == 5'(N_DIGITS));
            end
            for (int k = 0; k < N_DIGITS; k++) begin
                if (y16 >= band_top(k) && y16 < band_top(k) + BH) begin
                    digit_v = bus.digits[5*k +: 5];
                    rel_y   = y16 - band_top(k);
                    s0_d.hl = (bus.select == 5'(k));
                    if (digit_v <= 5'd9) begin
                        s0_d.cls = CLS_DIGIT;
                        addr_upd = bus.req_valid;
                    end
                end
            end
        end

`ifdef DFR_BLINK_EN
        if (blink_phase && s0_d.hl) begin
            s0_d.cls = CLS_BLANK;
        end
`endif

        col        = (x16 - X_LO) / SC;
        row        = rel_y / SC;
        rom_addr_d = addr_upd ? ROM_AW'(col) + ROM_AW'(row) * ROW_STRIDE
                                + ROM_AW'(digit_v) * GLYPH_STRIDE
                              : rom_addr_q;
    end

    // Output stage: rom_data lines up with the last entry of the tag delay line.
    always_comb begin
        pix = 16'h0000;
        case (dl_q[ROM_LAT-1].cls)
            CLS_DIGIT: pix = (dl_q[ROM_LAT-1].hl && bus.rom_data >= HL_THRESH)
                             ? 16'hFFFF : bus.rom_data;
            CLS_SEP:   pix = dl_q[ROM_LAT-1].hl ? 16'hFFFF : 16'h0000;
            default:   pix = 16'h0000;
        endcase
        rsp_data_d = dl_q[ROM_LAT-1].valid ? pix : rsp_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the tag delay line is a handful of flops, not a RAM, so it is
            // reset to guarantee no response escapes for requests dropped by reset.
            s0_q        <= '0;
            rom_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every stage samples its predecessor's old value.
            s0_q        <= s0_d;
            rom_addr_q  <= rom_addr_d;
            dl_q[0]     <= s0_q;
            for (int i = 1; i < ROM_LAT; i++) begin
                dl_q[i] <= dl_q[i-1];
            end
            rsp_valid_q <= dl_q[ROM_LAT-1].valid;
            rsp_data_q  <= rsp_data_d;
        end
    end

`ifdef DFR_BLINK_EN
    localparam int BW = $clog2(BLINK_CYCLES + 1);

    logic [BW-1:0] blink_cnt_d, blink_cnt_q;
    logic          blink_phase_d, blink_phase_q;

    always_comb begin
        blink_cnt_d   = blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign blink_phase = blink_phase_q;
`else
    assign blink_phase = 1'b0;
`endif

    assign bus.rom_addr  = rom_addr_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_digit_frame_renderer.sv
// Self-checking bench for digit_frame_renderer: directed frame/highlight cases,
// mid-stream reset, then randomized traffic against a geometric reference model.
module tb_digit_frame_renderer;

    localparam int B      = 12;
    localparam int GW     = 55;
    localparam int GH     = 16;
    localparam int S      = 2;
    localparam int ND     = 4;
    localparam int SEPA   = 2;
    localparam int SEPH   = 12;
    localparam int FW     = 2 * B + GW * S;
    localparam int FH     = 2 * B + ND * GH * S + SEPH;
    localparam int LAT    = 1 + 2;

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    logic clk;
    logic rst;

    digit_frame_renderer_if #(.N_DIGITS(ND), .ROM_AW(16)) bus ();

    digit_frame_renderer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cycle    = 0;
    int          n_rsp    = 0;
    exp_t        q[$];
    logic [15:0] exp_addr    = '0;
    logic [15:0] addr_pend   = '0;
    int          addr_due    = -1;
    logic [15:0] last_data   = '0;
    logic        rom_ovr_en  = 1'b0;
    logic [15:0] rom_ovr     = '0;

    // Synthetic glyph ROM contents; roughly half the words fall below the threshold.
    function automatic logic [15:0] rom_fn(input logic [15:0] a);
        logic [15:0] h;
        h = 16'(a * 16'd40503) ^ {a[4:0], a[15:5]};
        if (a[2]) h[15:11] = 5'd0;
        return h;
    endfunction

    always @(posedge clk) bus.rom_data <= rom_ovr_en ? rom_ovr : rom_fn(bus.rom_addr);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cycle, act, exp);
        end
    endtask

    // Walks the frame top to bottom; returns digit index, -2 for separator, -1 otherwise.
    function automatic int locate(input int x, input int y, output int rel);
        int top;
        rel = 0;
        if (x < B || x >= FW - B || y < B || y >= FH - B) return -1;
        top = B;
        for (int k = 0; k < ND; k++) begin
            if (k == SEPA) begin
                if (y >= top && y < top + SEPH) return -2;
                top += SEPH;
            end
            if (y >= top && y < top + GH * S) begin
                rel = y - top;
                return k;
            end
            top += GH * S;
        end
        return -1;
    endfunction

    task automatic model_push();
        int          x;
        int          y;
        int          rel;
        int          k;
        int          v;
        int          a;
        logic [15:0] rv;
        logic [15:0] pix;
        x   = int'(bus.req_x);
        y   = int'(bus.req_y);
        pix = 16'h0000;
        k   = locate(x, y, rel);
        if (k == -2) begin
            pix = (int'(bus.select) == ND) ? 16'hFFFF : 16'h0000;
        end else if (k >= 0) begin
            v = int'(bus.digits >> (5 * k)) & 31;
            if (v <= 9) begin
                a         = ((x - B) / S + (rel / S) * GW + v * GW * GH) % 65536;
                addr_pend = 16'(a);
                addr_due  = cycle + 1;
                rv        = rom_ovr_en ? rom_ovr : rom_fn(16'(a));
                pix       = (int'(bus.select) == k && rv >= 16'h0800) ? 16'hFFFF : rv;
            end
        end
        q.push_back('{due: cycle + LAT, data: pix});
    endtask

    task automatic model_flush();
        q.delete();
        exp_addr  = '0;
        addr_due  = -1;
        last_data = '0;
    endtask

    task automatic monitor();
        exp_t e;
        logic exp_v;
        if (addr_due == cycle) exp_addr = addr_pend;
        check("rom_addr", 32'(bus.rom_addr), 32'(exp_addr));
        while (q.size() > 0 && q[0].due < cycle) void'(q.pop_front());
        exp_v = (q.size() > 0 && q[0].due == cycle);
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
        if (exp_v) begin
            e = q.pop_front();
            check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
            last_data = e.data;
            if (bus.rsp_valid) n_rsp++;
        end else begin
            check("rsp_hold", 32'(bus.rsp_data), 32'(last_data));
        end
    endtask

    task automatic step();
        if (bus.req_valid && !rst) model_push();
        @(posedge clk);
        cycle++;
        #1;
        monitor();
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic req(input int x, input int y);
        bus.req_valid = 1'b1;
        bus.req_x     = 8'(x);
        bus.req_y     = 8'(y);
        step();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.digits    = '0;
        bus.select    = 5'd31;
        repeat (3) step();
        rst = 1'b0;
        idle(2);

        // Directed cases: border, plain digit, highlight around the threshold, separator, blank.
        bus.digits = {5'd5, 5'd12, 5'd7, 5'd3};
        rom_ovr_en = 1'b1;
        rom_ovr    = 16'h1234;
        req(0, 0);    idle(4);
        req(12, 12);  idle(4);
        bus.select = 5'd1;
        rom_ovr = 16'h0900; req(30, 50); idle(4);
        rom_ovr = 16'h07FF; req(30, 50); idle(4);
        rom_ovr = 16'h0800; req(30, 50); idle(4);
        bus.select = 5'd4; req(60, 80); idle(4);
        bus.select = 5'd0; req(60, 80); idle(4);
        req(40, 100); idle(4);
        req(200, 20); idle(4);
        req(133, 163); idle(4);
        req(121, 151); idle(4);

        // Changing select right behind an in-flight request must not affect it.
        bus.select = 5'd1;
        rom_ovr = 16'h0A00;
        req(20, 60);
        bus.select = 5'd31;
        req(20, 60);
        idle(5);
        rom_ovr_en = 1'b0;

        // Back-to-back stream with reset raised during the 10th request cycle.
        n0 = n_rsp;
        for (int i = 0; i < 20; i++) begin
            if (i == 9) begin
                rst = 1'b1;
                model_flush();
            end
            bus.req_valid = 1'b1;
            bus.req_x     = 8'($urandom_range(B, FW - B - 1));
            bus.req_y     = 8'($urandom_range(B, FH - B - 1));
            step();
        end
        bus.req_valid = 1'b0;
        rst = 1'b0;
        idle(6);
        check("rst_delivered", 32'(n_rsp - n0), 32'd7);

        // Randomized traffic with gaps and changing digits/select.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int k = 0; k < ND; k++) bus.digits[5*k +: 5] = 5'($urandom_range(0, 11));
            end
            if ($urandom_range(0, 3) == 0) bus.select = 5'($urandom_range(0, 6));
            bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.req_x     = 8'($urandom_range(0, 140));
            bus.req_y     = 8'($urandom_range(0, 170));
            step();
        end
        idle(6);
        check("drain", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/digit_frame_renderer.md
Name: digit_frame_renderer

Overview:
- Pixel source for the timer digit panel on the small LCD.
- Maps each requested (x,y) to a bordered frame holding N_DIGITS stacked glyph bands plus one separator band.
- Fetches glyph pixels from an external glyph ROM with configurable read latency and applies selected-digit highlight.
- Pipelined with valid tagging, so returned data stays aligned with its request. Sits between the LCD scan controller and the glyph ROM.

Parameters:
- BORDER, 12, frame border thickness in pixels (all four sides).
- GLYPH_W, 55, glyph width in ROM pixels.
- GLYPH_H, 16, glyph height in ROM pixels; one glyph = GLYPH_W*GLYPH_H words.
- SCALE, 2, integer upscale factor in x and y.
- N_DIGITS, 4, number of digit bands, top to bottom.
- SEP_AFTER, 2, separator band placed after digit index SEP_AFTER-1.
- SEP_H, 12, separator band height in rows.
- ROM_LAT, 1, glyph ROM read latency in cycles (>=1).
- ROM_AW, 16, ROM address width.
- HL_THRESH, 16'h0800, highlight threshold.
- BLINK_CYCLES, 25000000, blink half-period (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  pixel request strobe
- req_x  in  8  pixel column
- req_y  in  8  pixel row
- digits  in  5*N_DIGITS  packed digit values; digit k = bits [5k+4:5k]
- select  in  5  highlight target: 0..N_DIGITS-1 = digit, N_DIGITS = separator, else none
- rom_addr  out  ROM_AW  glyph ROM address
- rom_data  in  16  glyph ROM read data
- rsp_valid  out  1  response strobe
- rsp_data  out  16  RGB565 pixel

Behaviour:
- Geometry (defaults):
  - W = 2*BORDER + GLYPH_W*SCALE = 134; H = 2*BORDER + N_DIGITS*GLYPH_H*SCALE + SEP_H = 164.
  - Bands: digit0 y 12..43, digit1 44..75, separator 76..87, digit2 88..119, digit3 120..151.
  - Border region: x<BORDER, x>=W-BORDER, y<BORDER, y>=H-BORDER.
- Stage 0 (request cycle t, registered at end of t):
  - Classify the pixel as border, out-of-range (x>=W or y>=H), digit k, or separator.
  - Sample the digit value and select with the request.
  - For digit k with value v<=9: rom_addr = (x-BORDER)/SCALE + ((y-band_top)/SCALE)*GLYPH_W + v*GLYPH_W*GLYPH_H.
  - For any other class, or v>9 (blank): rom_addr holds its previous value and a class tag is carried instead.
- ROM stage: class, digit index and highlight flag are delayed ROM_LAT cycles alongside the ROM access.
- Output stage: rsp_valid and rsp_data become valid in cycle t+ROM_LAT+2 (default 3), exactly one response per request.
  - Border, out-of-range or blank digit: 0x0000.
  - Separator: 0xFFFF if select==N_DIGITS, else 0x0000.
  - Digit k with select==k: (rom_data >= HL_THRESH) ? 0xFFFF : rom_data.
  - Other digits: rom_data unchanged.
- Handshake:
  - No backpressure; a new request may be issued every cycle (full throughput).
  - Gaps in req_valid produce matching gaps in rsp_valid.
  - rsp_data holds its last value while rsp_valid=0.
- Changes to digits or select affect only requests presented after the change; in-flight pixels keep their sampled values.
- Reset:
  - rsp_valid=0, rsp_data=0, rom_addr=0; all pipeline valid bits cleared.
  - Reset mid-stream drops in-flight requests; no response is emitted for them.
  - First response after reset release appears ROM_LAT+2 cycles after the first new request.
- Arithmetic: division by SCALE uses the integer quotient; address products are computed at ROM_AW width; the address wraps modulo 2^ROM_AW.

Optional Feature:
- DFR_BLINK_EN defined:
  - Free-running counter toggles a blink phase every BLINK_CYCLES cycles; counter and phase reset to 0 (phase 0 = highlight on).
  - During phase 1 the selected digit renders as 0x0000 and a selected separator as 0x0000.
  - Phase is sampled at stage 0 with the request.
- DFR_BLINK_EN undefined: highlight is static and no counter is built.

Test Plan:
- Border pixel (0,0) at t: req_valid=1 -> rsp_valid=1 at t+3, rsp_data=0x0000; no response at any other cycle.
- (12,12), digit0=3, select=31 -> rom_addr=2640 at t+1; ROM returns 0x1234 -> rsp_data=0x1234 at t+3.
- (30,50), digit1=7, select=1, rom_data=0x0900 -> rsp_data=0xFFFF; repeat with rom_data=0x07FF -> 0x07FF.
- Separator (60,80): select=4 -> 0xFFFF; select=0 -> 0x0000. Digit value 12 in band 2 -> 0x0000.
- Stream 20 back-to-back requests and assert rst on the 10th cycle -> responses 1..7 delivered in order, nothing for in-flight requests, rsp_valid=0 during reset.
- With DFR_BLINK_EN and BLINK_CYCLES=8: selected bright pixel -> 0xFFFF for 8 cycles, then 0x0000 for 8 cycles, alternating.
